// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame state codes and the data-bit count helper.
package uart_rx_pkg;

   typedef enum logic [3:0] {
      RX_IDLE       = 4'd0,
      RX_START_BIT  = 4'd1,
      RX_DATA_BIT_0 = 4'd2,
      RX_DATA_BIT_1 = 4'd3,
      RX_DATA_BIT_2 = 4'd4,
      RX_DATA_BIT_3 = 4'd5,
      RX_DATA_BIT_4 = 4'd6,
      RX_DATA_BIT_5 = 4'd7,
      RX_DATA_BIT_6 = 4'd8,
      RX_DATA_BIT_7 = 4'd9,
      RX_PARITY_BIT = 4'd10,
      RX_STOP_BIT   = 4'd11
   } rx_state_t;

   // State code of the last data bit: once its sample is taken, all bits are received.
   function automatic logic [3:0] all_bits_received(input int data_width);
      return 4'(int'(RX_DATA_BIT_0) + data_width - 1);
   endfunction

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Receive-side word handshake between the UART sequencer and its consumer.
interface uart_rx_sequencer_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  parity_error;
   logic                  framing_error;
   logic                  overrun_error;

   modport master (
      output rx_data, rx_valid, parity_error, framing_error, overrun_error,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, parity_error, framing_error, overrun_error,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_oversample_counter.sv
// Oversample counter and mid-bit sampling strobe for the UART receiver.
module uart_rx_oversample_counter
   import uart_rx_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      baud_tick,
   input  logic      serial_in_synced,
   input  rx_state_t state,
   output logic      sampling_strobe
);

   localparam int             CW   = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0]  MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0]  LAST = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] count;

   // Restart the bit timebase on a falling line seen in idle, otherwise count baud ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (state == RX_IDLE && !serial_in_synced) begin
         count <= '0;
      end else if (baud_tick) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   // Mid-bit strobe; suppressed in idle so a stray count match never samples.
   always_comb begin
      sampling_strobe = !reset && baud_tick && (count == MID) && (state != RX_IDLE);
   end

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive frame sequencer: frame FSM, data shift register and one-word output buffer.
module uart_rx_sequencer
   import uart_rx_pkg::*;
#(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int PARITY_ENABLED   = 1,
   parameter int PARITY_ODD       = 0,
   parameter int OVERSAMPLE       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic                 serial_in_synced,
   input  logic                 start_detected,
   output logic [3:0]           state,
   output logic                 sampling_strobe,
   uart_rx_sequencer_if.master  rx_bus
);

   localparam logic [3:0] LAST_DATA = all_bits_received(INPUT_DATA_WIDTH);

   rx_state_t                   state_q;
   rx_state_t                   state_d;
   logic                        shift_en;
   logic                        parity_en;
   logic                        frame_done;
   logic [INPUT_DATA_WIDTH-1:0] shift_reg;
   logic                        parity_flag;
   logic [INPUT_DATA_WIDTH-1:0] data_q;
   logic                        valid_q;
   logic                        perr_q;
   logic                        ferr_q;
   logic                        overrun_q;

   uart_rx_oversample_counter #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_counter (
      .clk              (clk),
      .reset            (reset),
      .baud_tick        (baud_tick),
      .serial_in_synced (serial_in_synced),
      .state            (state_q),
      .sampling_strobe  (sampling_strobe)
   );

   // Frame state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-bit datapath enables; every transition after idle waits for the mid-bit strobe.
   always_comb begin
      state_d    = state_q;
      shift_en   = 1'b0;
      parity_en  = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!serial_in_synced) begin
               state_d = RX_START_BIT;
            end
         end
         RX_START_BIT: begin
            if (sampling_strobe) begin
               state_d = (!serial_in_synced && start_detected) ? RX_DATA_BIT_0 : RX_IDLE;
            end
         end
         RX_DATA_BIT_0, RX_DATA_BIT_1, RX_DATA_BIT_2, RX_DATA_BIT_3,
         RX_DATA_BIT_4, RX_DATA_BIT_5, RX_DATA_BIT_6, RX_DATA_BIT_7: begin
            if (sampling_strobe) begin
               shift_en = 1'b1;
               if (state_q == LAST_DATA) begin
                  state_d = (PARITY_ENABLED != 0) ? RX_PARITY_BIT : RX_STOP_BIT;
               end else begin
                  state_d = rx_state_t'(state_q + 4'd1);
               end
            end
         end
         RX_PARITY_BIT: begin
            if (sampling_strobe) begin
               parity_en = 1'b1;
               state_d   = RX_STOP_BIT;
            end
         end
         RX_STOP_BIT: begin
            if (sampling_strobe) begin
               frame_done = 1'b1;
               state_d    = RX_IDLE;
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   // Shift data in LSB-first and evaluate parity against the received word.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg   <= '0;
         parity_flag <= 1'b0;
      end else begin
         if (state_q == RX_START_BIT) begin
            parity_flag <= 1'b0;
         end
         if (shift_en) begin
            shift_reg <= {serial_in_synced, shift_reg[INPUT_DATA_WIDTH-1:1]};
         end
         if (parity_en) begin
            parity_flag <= (^shift_reg) ^ serial_in_synced ^ 1'(PARITY_ODD);
         end
      end
   end

   // Output buffer: load a finished frame when the slot is free or being drained, else flag overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (frame_done) begin
            if (!valid_q || rx_bus.rx_ready) begin
               data_q  <= shift_reg;
               perr_q  <= parity_flag;
               ferr_q  <= !serial_in_synced;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && rx_bus.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign state                = state_q;
   assign rx_bus.rx_data       = data_q;
   assign rx_bus.rx_valid      = valid_q;
   assign rx_bus.parity_error  = perr_q;
   assign rx_bus.framing_error = ferr_q;
   assign rx_bus.overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: 8 data bits, even parity, 16x oversampling.
module tb_uart_rx_sequencer;

   localparam int W        = 8;
   localparam int BIT_CLKS = 32;   // 16 baud ticks per bit, one tick every 2 clocks

   logic clk        = 1'b0;
   logic reset      = 1'b1;
   logic baud_tick  = 1'b0;
   logic serial_in  = 1'b1;
   logic det_en     = 1'b1;
   logic start_detected;
   logic [3:0] state;
   logic       sampling_strobe;

   int checks   = 0;
   int failures = 0;
   int ovr_cnt  = 0;
   bit cmp_en   = 1'b0;
   bit rec_en   = 1'b0;
   logic [3:0] rec_q[$];

   // Behavioural reference: bits collected at the mid-bit point of each frame slot.
   bit          m_active = 1'b0;
   int          m_ticks  = 0;
   int          m_nsamp  = 0;
   logic [10:0] m_word   = '0;
   bit          m_valid  = 1'b0;
   logic [7:0]  m_data   = '0;
   bit          m_perr   = 1'b0;
   bit          m_ferr   = 1'b0;
   bit          m_ovr    = 1'b0;

   uart_rx_sequencer_if #(.DATA_WIDTH(W)) rx_bus ();

   assign start_detected = !serial_in && det_en;

   uart_rx_sequencer #(
      .INPUT_DATA_WIDTH (W),
      .PARITY_ENABLED   (1),
      .PARITY_ODD       (0),
      .OVERSAMPLE       (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .baud_tick        (baud_tick),
      .serial_in_synced (serial_in),
      .start_detected   (start_detected),
      .state            (state),
      .sampling_strobe  (sampling_strobe),
      .rx_bus           (rx_bus)
   );

   always #5 clk = ~clk;

   // Baud tick on every other clock.
   initial begin
      forever begin
         @(posedge clk);
         #1 baud_tick = ~baud_tick;
      end
   end

   // Reference model: a frame starts on the first low line seen while idle; each slot is
   // sampled on the 8th, 24th, 40th ... baud tick after that; slot 0 start, 1..8 data, 9 parity, 10 stop.
   always @(posedge clk) begin : model
      bit act, vld, ovr, done;
      int tk, ns;
      logic [10:0] w;
      act  = m_active;
      tk   = m_ticks;
      ns   = m_nsamp;
      vld  = m_valid;
      w    = m_word;
      ovr  = 1'b0;
      done = 1'b0;
      if (reset) begin
         act = 1'b0; tk = 0; ns = 0; vld = 1'b0;
         m_data <= '0; m_perr <= 1'b0; m_ferr <= 1'b0;
      end else begin
         if (!act) begin
            if (!serial_in) begin
               act = 1'b1; tk = 0; ns = 0;
            end
         end else if (baud_tick) begin
            tk = tk + 1;
            if (tk % 16 == 8) begin
               w[ns] = serial_in;
               if (ns == 0 && (serial_in || !start_detected)) begin
                  act = 1'b0;
               end else if (ns == 10) begin
                  act  = 1'b0;
                  done = 1'b1;
               end else begin
                  ns = ns + 1;
               end
            end
         end
         if (done) begin
            if (!vld || rx_bus.rx_ready) begin
               m_data <= w[8:1];
               m_perr <= ^w[9:1];
               m_ferr <= !w[10];
               vld = 1'b1;
            end else begin
               ovr = 1'b1;
            end
         end else if (vld && rx_bus.rx_ready) begin
            vld = 1'b0;
         end
      end
      m_active <= act;
      m_ticks  <= tk;
      m_nsamp  <= ns;
      m_word   <= w;
      m_valid  <= vld;
      m_ovr    <= ovr;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of every output against the reference model.
   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("state", 32'(state), m_active ? 32'(1 + m_nsamp) : 32'd0);
         checkOutput("sampling_strobe", 32'(sampling_strobe),
                     32'(!reset && m_active && baud_tick && ((m_ticks + 1) % 16 == 8)));
         checkOutput("rx_valid", 32'(rx_bus.rx_valid), 32'(m_valid));
         checkOutput("rx_data", 32'(rx_bus.rx_data), 32'(m_data));
         checkOutput("parity_error", 32'(rx_bus.parity_error), 32'(m_perr));
         checkOutput("framing_error", 32'(rx_bus.framing_error), 32'(m_ferr));
         checkOutput("overrun_error", 32'(rx_bus.overrun_error), 32'(m_ovr));
      end
   end

   // Overrun pulse counter and state-change recorder for the literal checks.
   always @(negedge clk) begin
      if (cmp_en && rx_bus.overrun_error) ovr_cnt <= ovr_cnt + 1;
      if (rec_en && state != rec_q[$]) rec_q.push_back(state);
   end

   task automatic applyStimulus(input logic b, input int clks);
      serial_in = b;
      repeat (clks) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendFrame(input logic [7:0] d, input bit flip, input bit stop);
      applyStimulus(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) applyStimulus(d[i], BIT_CLKS);
      applyStimulus((^d) ^ flip, BIT_CLKS);
      if (stop) applyStimulus(1'b1, BIT_CLKS);
      else      applyStimulus(1'b0, 24);
      applyStimulus(1'b1, 48);
   endtask

   task automatic consume();
      rx_bus.rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_bus.rx_ready = 1'b0;
   endtask

   // Global time bound so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rx_bus.rx_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", 32'(state), 32'd0);
      checkOutput("reset_valid", 32'(rx_bus.rx_valid), 32'd0);
      checkOutput("reset_data", 32'(rx_bus.rx_data), 32'd0);
      checkOutput("reset_perr", 32'(rx_bus.parity_error), 32'd0);
      checkOutput("reset_ferr", 32'(rx_bus.framing_error), 32'd0);
      checkOutput("reset_ovr", 32'(rx_bus.overrun_error), 32'd0);
      checkOutput("reset_strobe", 32'(sampling_strobe), 32'd0);
      reset  = 1'b0;
      cmp_en = 1'b1;
      applyStimulus(1'b1, 20);

      // Clean 0xA5 with the full state walk recorded.
      rec_q.delete();
      rec_q.push_back(state);
      rec_en = 1'b1;
      sendFrame(8'hA5, 1'b0, 1'b1);
      rec_en = 1'b0;
      checkOutput("a5_valid", 32'(rx_bus.rx_valid), 32'd1);
      checkOutput("a5_data", 32'(rx_bus.rx_data), 32'hA5);
      checkOutput("a5_perr", 32'(rx_bus.parity_error), 32'd0);
      checkOutput("a5_ferr", 32'(rx_bus.framing_error), 32'd0);
      checkOutput("a5_seq_len", 32'(rec_q.size()), 32'd13);
      for (int i = 0; i < 13; i++) begin
         checkOutput("a5_seq", (i < rec_q.size()) ? 32'(rec_q[i]) : 32'hFFFF,
                     (i < 12) ? 32'(i) : 32'd0);
      end
      consume();
      checkOutput("a5_consumed", 32'(rx_bus.rx_valid), 32'd0);

      // Parity bit flipped.
      sendFrame(8'h3C, 1'b1, 1'b1);
      checkOutput("3c_data", 32'(rx_bus.rx_data), 32'h3C);
      checkOutput("3c_perr", 32'(rx_bus.parity_error), 32'd1);
      checkOutput("3c_ferr", 32'(rx_bus.framing_error), 32'd0);
      consume();

      // Stop bit low, then a clean frame.
      sendFrame(8'h55, 1'b0, 1'b0);
      checkOutput("55_ferr", 32'(rx_bus.framing_error), 32'd1);
      checkOutput("55_data", 32'(rx_bus.rx_data), 32'h55);
      checkOutput("55_idle", 32'(state), 32'd0);
      consume();
      sendFrame(8'h0F, 1'b0, 1'b1);
      checkOutput("0f_data", 32'(rx_bus.rx_data), 32'h0F);
      checkOutput("0f_perr", 32'(rx_bus.parity_error), 32'd0);
      checkOutput("0f_ferr", 32'(rx_bus.framing_error), 32'd0);
      consume();

      // Glitch of 4 baud ticks: start bit aborts.
      applyStimulus(1'b0, 8);
      applyStimulus(1'b1, 64);
      checkOutput("glitch_valid", 32'(rx_bus.rx_valid), 32'd0);
      checkOutput("glitch_idle", 32'(state), 32'd0);

      // Low line without start qualification: aborts too.
      det_en = 1'b0;
      applyStimulus(1'b0, BIT_CLKS);
      applyStimulus(1'b1, 64);
      det_en = 1'b1;
      checkOutput("nodet_valid", 32'(rx_bus.rx_valid), 32'd0);
      checkOutput("nodet_idle", 32'(state), 32'd0);

      // Two frames with no consumer: second is dropped.
      ovr_cnt = 0;
      sendFrame(8'h11, 1'b0, 1'b1);
      sendFrame(8'h22, 1'b0, 1'b1);
      checkOutput("ovr_count", 32'(ovr_cnt), 32'd1);
      checkOutput("ovr_data", 32'(rx_bus.rx_data), 32'h11);
      checkOutput("ovr_valid", 32'(rx_bus.rx_valid), 32'd1);
      consume();
      checkOutput("ovr_drained", 32'(rx_bus.rx_valid), 32'd0);

      // Reset in the middle of data bit 3 of 0x99, then a clean 0x66.
      ovr_cnt = 0;
      applyStimulus(1'b0, BIT_CLKS);
      applyStimulus(1'b1, BIT_CLKS);
      applyStimulus(1'b0, BIT_CLKS);
      applyStimulus(1'b0, BIT_CLKS);
      applyStimulus(1'b1, 8);
      checkOutput("99_bit3_state", 32'(state), 32'd5);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("99_rst_state", 32'(state), 32'd0);
      checkOutput("99_rst_valid", 32'(rx_bus.rx_valid), 32'd0);
      checkOutput("99_rst_data", 32'(rx_bus.rx_data), 32'd0);
      checkOutput("99_rst_strobe", 32'(sampling_strobe), 32'd0);
      reset = 1'b0;
      applyStimulus(1'b1, 64);
      checkOutput("99_no_valid", 32'(rx_bus.rx_valid), 32'd0);
      sendFrame(8'h66, 1'b0, 1'b1);
      checkOutput("66_data", 32'(rx_bus.rx_data), 32'h66);
      checkOutput("66_valid", 32'(rx_bus.rx_valid), 32'd1);
      checkOutput("66_perr", 32'(rx_bus.parity_error), 32'd0);
      checkOutput("66_ferr", 32'(rx_bus.framing_error), 32'd0);
      checkOutput("66_no_ovr", 32'(ovr_cnt), 32'd0);
      consume();
      applyStimulus(1'b1, 4);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_sequencer.md
UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 Parameter INPUT_DATA_WIDTH, default 8, number of data bits per frame (legal 5..8).
REQ-002 Parameter PARITY_ENABLED, default 1, parity bit present when 1.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-004 Parameter OVERSAMPLE, default 16, baud_tick pulses per bit period (power of 2, >= 8).
REQ-005 clk  input  1  clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 baud_tick  input  1  one-cycle pulse at OVERSAMPLE x baud rate.
REQ-008 serial_in_synced  input  1  already-synchronised Rx line; idle high.
REQ-009 start_detected  input  1  start-bit qualifier from the start-bit detector.
REQ-010 rx_ready  input  1  consumer accepts rx_data while rx_valid is high.
REQ-011 state  output  4  current frame state.
REQ-012 sampling_strobe  output  1  one-cycle mid-bit sample pulse; also drives the start-bit detector.
REQ-013 rx_data  output  INPUT_DATA_WIDTH  received word, LSB first on the line.
REQ-014 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-015 parity_error  output  1  parity mismatch status of the word in rx_data.
REQ-016 framing_error  output  1  stop bit sampled low for the word in rx_data.
REQ-017 overrun_error  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-018 State encoding: IDLE=0, START_BIT=1, DATA_BIT_n=2+n, PARITY_BIT=10, STOP_BIT=11; codes 12..15 return to IDLE on the next clk.
REQ-019 Oversample counter (log2 OVERSAMPLE bits): cleared on the clk where IDLE sees serial_in_synced low; otherwise increments on each baud_tick and wraps at OVERSAMPLE-1.
REQ-020 sampling_strobe asserts for one clk when baud_tick=1 and counter=OVERSAMPLE/2-1; it never asserts in IDLE.
REQ-021 IDLE -> START_BIT on the first clk with serial_in_synced=0.
REQ-022 START_BIT on strobe: -> DATA_BIT_0 if serial_in_synced=0 and start_detected=1; otherwise -> IDLE (false start, no output change).
REQ-023 DATA_BIT_n on strobe: shift serial_in_synced into the MSB of the shift register (shift right); -> DATA_BIT_n+1, or after bit INPUT_DATA_WIDTH-1 -> PARITY_BIT if PARITY_ENABLED, else -> STOP_BIT.
REQ-024 PARITY_BIT on strobe: capture the line; the parity flag is set when (XOR of data bits XOR the sampled bit XOR PARITY_ODD) is 1.
REQ-025 STOP_BIT on strobe: -> IDLE; the frame completes on this strobe.
REQ-026 Frame completion with rx_valid=0, or rx_valid=1 and rx_ready=1 in the same clk:
  - load rx_data, parity_error and framing_error (framing_error = stop bit sampled 0);
  - rx_valid=1 on the next clk.
REQ-027 Frame completion with rx_valid=1 and rx_ready=0:
  - rx_data and status flags are retained;
  - overrun_error pulses for one clk.
REQ-028 rx_valid=1 and rx_ready=1 without a completion: rx_valid=0 next clk; rx_data is held.
REQ-029 rx_data, parity_error and framing_error stay stable while rx_valid=1.
REQ-030 A framing error still returns the FSM to IDLE; re-arm requires the line to be seen low again in IDLE.

Reset
REQ-031 Reset values: state=IDLE, counter=0, shift register=0, rx_data=0, rx_valid=0, all error outputs=0, sampling_strobe=0.
REQ-032 Reset asserted mid-frame abandons the frame within one clk; no rx_valid and no overrun_error result from it.

Structure
REQ-033 The Rx_* state constants (4-bit) live in a shared package uart_rx_pkg, also used by detect_start_bit; the package also provides a function for the ALL_BITS_RECEIVED count.
REQ-034 One sub-module, uart_rx_oversample_counter, owns the counter and sampling_strobe generation; the FSM, shift register and output buffer stay in the top.

Verification
REQ-035 Frame 0xA5, even parity, correct parity bit 0, stop=1 -> rx_data=0xA5, rx_valid=1, no error flags, state sequence 0,1,2..9,10,11,0.
REQ-036 Frame 0x3C with parity bit flipped -> rx_data=0x3C, parity_error=1, framing_error=0.
REQ-037 Frame 0x55 with stop=0 -> framing_error=1, FSM back in IDLE, next frame 0x0F received cleanly.
REQ-038 Line low for 4 baud_ticks then high -> START_BIT aborts to IDLE on strobe, rx_valid stays 0.
REQ-039 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 retained, one overrun_error pulse; rx_ready=1 then clears rx_valid.
REQ-040 Reset at DATA_BIT_3 of frame 0x99 -> all outputs at reset values next clk; a following frame 0x66 received correctly.
